vs_ram_burst_reader: RTL and testbench
======================================

# vs_ram_burst_reader

Read-side sequencer that sits directly downstream of `vs_single_clock_synchronous_ram`. On a start command it walks a contiguous address range, drives the RAM's `read_addr`, absorbs the RAM's registered-read latency, and presents the returned bytes as a valid/ready stream with a last-beat marker. Full throughput (one beat per cycle) is sustained under no backpressure; arbitrary backpressure never drops or duplicates a beat.

## Interface
- `ADDR_WIDTH`, default 16: RAM address width; matches the RAM's read port.
- `DATA_WIDTH`, default 8: RAM data width.
- `LEN_WIDTH`, default 16: burst length counter width, in beats.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `start`  in  1: burst request; sampled only when `busy`=0.
- `start_addr`  in  ADDR_WIDTH: first address of the burst.
- `length`  in  LEN_WIDTH: number of beats; 0 is legal.
- `busy`  out  1: burst in progress.
- `done`  out  1: one-cycle pulse when a burst completes.
- `ram_read_addr`  out  ADDR_WIDTH: registered; connects to RAM `read_addr`.
- `ram_out_data`  in  DATA_WIDTH: connects to RAM `out_data`.
- `out_valid`  out  1: `out_data` holds a beat.
- `out_ready`  in  1: consumer accepts the beat when `out_valid`=1.
- `out_data`  out  DATA_WIDTH: beat payload.
- `out_last`  out  1: qualifies the final beat of the burst.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: `busy`=0. `start`=1 → load address counter with `start_addr`, remaining-issue counter and remaining-beat counter with `length`. Then go to RUN, or to FINISH if `length`=0.
- RUN: a read is issued in any cycle where issues remain and the issue condition `count + inflight - pop < 2` holds:
  - `count` is output-buffer occupancy (0..2);
  - `inflight` is 1 if a read was issued last cycle;
  - `pop` is `out_valid && out_ready`.
- Issue: `ram_read_addr` presents the current address this cycle; the address counter increments and the issue counter decrements at the edge.
- Capture: the RAM returns data the cycle after an issue. It is captured into a 2-entry FIFO at the end of that cycle, in order.
- Pop: the remaining-beat counter decrements. `out_last`=1 when the head entry is the final beat.
- After the final beat pops, go to FINISH. FINISH lasts one cycle with `done`=1 and `busy`=1, then returns to IDLE.
- Address counter wraps modulo 2^ADDR_WIDTH; 0xFFFF is followed by 0x0000.
- `start` while `busy`=1 is ignored. `start_addr` and `length` are sampled only on accepted start.
- `ram_read_addr` holds its last value when not issuing. RAM reads have no side effects.
- `out_data` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `ram_read_addr`=0, FIFO empty, state IDLE.
- Reset asserted mid-burst: the next cycle is IDLE with all outputs at reset values. The in-flight RAM return is discarded.
- First-beat latency: start accepted at edge 0 → first issue in cycle 1 → RAM data in cycle 2 → `out_valid`=1 in cycle 3.
- With `out_ready` held 1, beats appear in consecutive cycles 3 .. 3+length-1. `done` pulses in cycle 3+length.
- `length`=0: `done` pulses in cycle 1; no beats and no issues.
- Simultaneous pop and capture with FIFO full is legal; occupancy stays 2.
- A new start is accepted at the earliest in the cycle after `done`.

## Structure
- Shared package `vs_mem_pkg` holds:
  - the state enum `vs_burst_state_t`;
  - the typedefs `vs_ram_addr_t` and `vs_ram_data_t` (16/8-bit defaults), shared with the RAM bench.
- Sub-module `vs_fifo2`: 2-entry synchronous FIFO carrying data and last flag, with push/pop/count. It holds the output buffer and is reused by later memory stages.
- The counters and FSM stay in the top module.

## Test plan
- RAM preloaded with `mem[i]=i`. Start `start_addr`=0, `length`=10, `out_ready`=1 → beats 0..9 in cycles 3..12, `out_last` only on 9, `done` in cycle 13.
- Same burst with `out_ready` toggling 1,0,0,1 repeating → values 0..9 in order, no gaps or duplicates, data stable during stalls.
- `start_addr`=0xFFFE, `length`=4 → `ram_read_addr` sequence FFFE, FFFF, 0000, 0001; beats match `mem` at those addresses.
- `length`=0 → `done` in cycle 1, `out_valid` never asserts, `ram_read_addr` unchanged.
- Assert `reset` in cycle 5 of a 10-beat burst → cycle 6: `busy`=0, `out_valid`=0. A following burst from address 3 returns 3,4,5 correctly.
- Pulse `start` during a busy burst with different `start_addr` → ignored; the original burst completes unchanged.

Source files
------------

// File: rtl/vs_mem_pkg.sv
// Shared memory-subsystem types: RAM word/address typedefs and the
// burst reader state encoding.
package vs_mem_pkg;

    localparam int VS_RAM_ADDR_W  = 16;
    localparam int VS_RAM_DATA_W  = 8;
    localparam int VS_BURST_LEN_W = 16;

    typedef logic [VS_RAM_ADDR_W-1:0] vs_ram_addr_t;
    typedef logic [VS_RAM_DATA_W-1:0] vs_ram_data_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } vs_burst_state_t;

endpackage

// File: rtl/vs_fifo2.sv
// Two-entry synchronous FIFO carrying a data word and a last flag.
// Push and pop in the same cycle are allowed even when full.
module vs_fifo2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last
);

    logic [DATA_WIDTH-1:0] data_q [2];
    logic                  last_q [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // When full, the slot being written is the one popped this cycle.
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr] & (count != 2'd0);

endmodule

// File: rtl/vs_ram_burst_reader.sv
// Burst read sequencer for a registered-read RAM; streams a contiguous
// address range out as valid/ready beats with a last marker.
module vs_ram_burst_reader
    import vs_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = VS_RAM_ADDR_W,
    parameter int DATA_WIDTH = VS_RAM_DATA_W,
    parameter int LEN_WIDTH  = VS_BURST_LEN_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    vs_burst_state_t state_q;
    vs_burst_state_t state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  issue_left;
    logic [LEN_WIDTH-1:0]  beat_left;
    logic                  inflight;
    logic                  inflight_last;

    logic       run;
    logic       accept;
    logic       issue;
    logic       pop;
    logic [1:0] fifo_count;
    logic [2:0] occ;

    assign accept = (state_q == ST_IDLE) && start;
    assign pop    = out_valid && out_ready;

    // Projected buffer occupancy two cycles out; keeps the FIFO from overflowing.
    assign occ   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue = run && (issue_left != '0) && (occ < 3'd2);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pop && (beat_left == LEN_WIDTH'(1))) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b1;
        done = 1'b0;
        run  = 1'b0;
        unique case (state_q)
            ST_IDLE:   busy = 1'b0;
            ST_RUN:    run  = 1'b1;
            ST_FINISH: done = 1'b1;
            default:   busy = 1'b0;
        endcase
    end

    // The address register is what the RAM sees; it stays on the final
    // address after the last issue so the port holds its last value.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q        <= '0;
            issue_left    <= '0;
            beat_left     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (issue_left == LEN_WIDTH'(1));
            if (accept) begin
                issue_left <= length;
                beat_left  <= length;
                if (length != '0) begin
                    addr_q <= start_addr;
                end
            end else begin
                if (issue) begin
                    issue_left <= issue_left - LEN_WIDTH'(1);
                    if (issue_left != LEN_WIDTH'(1)) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                    end
                end
                if (pop) begin
                    beat_left <= beat_left - LEN_WIDTH'(1);
                end
            end
        end
    end

    assign ram_read_addr = addr_q;

    vs_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (inflight),
        .push_data(ram_out_data),
        .push_last(inflight_last),
        .pop      (pop),
        .count    (fifo_count),
        .head_data(out_data),
        .head_last(out_last)
    );

    assign out_valid = (fifo_count != 2'd0);

endmodule

// File: tb/tb_vs_ram_burst_reader.sv
// Bench for vs_ram_burst_reader: behavioural RAM, expected-beat list,
// per-cycle stream checker and directed literal checks.
module tb_vs_ram_burst_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_addr = 16'h0;
    logic [15:0] length = 16'h0;
    logic        busy;
    logic        done;
    logic [15:0] ram_read_addr;
    logic [7:0]  ram_out_data = 8'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;

    vs_ram_burst_reader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .ram_read_addr(ram_read_addr),
        .ram_out_data (ram_out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [65536];

    always @(posedge clock) ram_out_data <= mem[ram_read_addr];

    // Expected beats: written by stimulus, consumed by the checker.
    logic [7:0] exp_data [256];
    logic       exp_last [256];
    int         exp_wr = 0;
    int         exp_rd = 0;

    int n_cmp = 0;
    int n_err = 0;
    int beats_seen = 0;
    logic [7:0] last_data = 8'h0;

    string       req_name = "";
    logic [31:0] req_act = 0;
    logic [31:0] req_exp = 0;
    int          req_seq = 0;
    int          req_seen = 0;

    logic        stall_q = 1'b0;
    logic [7:0]  stall_data = 8'h0;
    logic        stall_last = 1'b0;

    initial forever begin
        @(negedge clock);
        if (req_seq != req_seen) begin
            req_seen = req_seq;
            n_cmp++;
            if (req_act !== req_exp) begin
                n_err++;
                $display("FAIL %s: got %0h want %0h", req_name, req_act, req_exp);
            end
        end
        if (reset) begin
            exp_rd  = exp_wr;
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== stall_data ||
                    out_last !== stall_last) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%0b d=%0h l=%0b want v=1 d=%0h l=%0b",
                             out_valid, out_data, out_last, stall_data, stall_last);
                end
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (exp_rd == exp_wr) begin
                    n_err++;
                    $display("FAIL extra_beat: got d=%0h want no beat", out_data);
                end else if (out_data !== exp_data[exp_rd] ||
                             out_last !== exp_last[exp_rd]) begin
                    n_err++;
                    $display("FAIL beat: got d=%0h l=%0b want d=%0h l=%0b",
                             out_data, out_last, exp_data[exp_rd], exp_last[exp_rd]);
                end
                if (out_ready && exp_rd != exp_wr) begin
                    exp_rd++;
                    beats_seen++;
                    last_data = out_data;
                end
            end
            if (done === 1'b1) begin
                n_cmp++;
                if (exp_rd != exp_wr) begin
                    n_err++;
                    $display("FAIL done_early: got %0d beats left want 0", exp_wr - exp_rd);
                end
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        req_name = name;
        req_act  = act;
        req_exp  = exp;
        req_seq++;
        @(negedge clock);
        #1;
    endtask

    logic [15:0] addr_log [0:300];

    task automatic push_expected(input logic [15:0] addr, input logic [15:0] len);
        for (int i = 0; i < int'(len); i++) begin
            logic [15:0] a;
            a = addr + 16'(i);
            exp_data[exp_wr] = mem[a];
            exp_last[exp_wr] = (i == int'(len) - 1);
            exp_wr++;
        end
    endtask

    task automatic run_burst(input logic [15:0] addr, input logic [15:0] len,
                             input bit toggle, input int poke,
                             output int first_v, output int done_c);
        first_v = 0;
        done_c  = 0;
        @(posedge clock); #1;
        start      = 1'b1;
        start_addr = addr;
        length     = len;
        out_ready  = 1'b1;
        push_expected(addr, len);
        for (int c = 1; c <= 300 && done_c == 0; c++) begin
            @(posedge clock); #1;
            start = (c == poke);
            if (c == poke) begin
                start_addr = 16'h0080;
                length     = 16'd7;
            end
            out_ready = toggle ? ((c % 4 == 1) || (c % 4 == 0)) : 1'b1;
            #3;
            addr_log[c] = ram_read_addr;
            if (out_valid && first_v == 0) first_v = c;
            if (done) done_c = c;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (done_c == 0) lit("burst_timeout", 32'(0), 32'(1));
    endtask

    int fv;
    int dc;
    int base;
    logic [15:0] held;
    logic b6, v6;
    logic [15:0] a6;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);

        repeat (3) @(posedge clock);
        #4;
        lit("rst_busy", 32'(busy), 32'(0));
        lit("rst_done", 32'(done), 32'(0));
        lit("rst_valid", 32'(out_valid), 32'(0));
        lit("rst_last", 32'(out_last), 32'(0));
        lit("rst_data", 32'(out_data), 32'(0));
        lit("rst_raddr", 32'(ram_read_addr), 32'(0));
        @(posedge clock); #1;
        reset = 1'b0;

        // Full-rate burst of 10 from address 0
        base = beats_seen;
        run_burst(16'h0000, 16'd10, 1'b0, 0, fv, dc);
        @(posedge clock); #4;
        lit("t1_done_pulse", 32'(done), 32'(0));
        lit("t1_first_valid", 32'(fv), 32'(3));
        lit("t1_done_cycle", 32'(dc), 32'(13));
        lit("t1_raddr_c1", 32'(addr_log[1]), 32'h0000);
        lit("t1_raddr_c10", 32'(addr_log[10]), 32'h0009);
        lit("t1_beats", 32'(beats_seen - base), 32'(10));
        lit("t1_last_data", 32'(last_data), 32'h09);

        // Same burst under 1,0,0,1 backpressure
        base = beats_seen;
        run_burst(16'h0000, 16'd10, 1'b1, 0, fv, dc);
        lit("t2_first_valid", 32'(fv), 32'(3));
        lit("t2_beats", 32'(beats_seen - base), 32'(10));
        lit("t2_last_data", 32'(last_data), 32'h09);

        // Address wrap
        base = beats_seen;
        run_burst(16'hFFFE, 16'd4, 1'b0, 0, fv, dc);
        lit("t3_raddr_c1", 32'(addr_log[1]), 32'hFFFE);
        lit("t3_raddr_c2", 32'(addr_log[2]), 32'hFFFF);
        lit("t3_raddr_c3", 32'(addr_log[3]), 32'h0000);
        lit("t3_raddr_c4", 32'(addr_log[4]), 32'h0001);
        lit("t3_done_cycle", 32'(dc), 32'(7));
        lit("t3_beats", 32'(beats_seen - base), 32'(4));
        lit("t3_last_data", 32'(last_data), 32'h01);

        // Zero-length burst
        held = ram_read_addr;
        base = beats_seen;
        run_burst(16'h1234, 16'd0, 1'b0, 0, fv, dc);
        lit("t4_done_cycle", 32'(dc), 32'(1));
        lit("t4_no_valid", 32'(fv), 32'(0));
        lit("t4_raddr_held", 32'(addr_log[1]), 32'(held));
        lit("t4_beats", 32'(beats_seen - base), 32'(0));

        // Reset in cycle 5 of a 10-beat burst
        @(posedge clock); #1;
        start      = 1'b1;
        start_addr = 16'h0000;
        length     = 16'd10;
        out_ready  = 1'b1;
        push_expected(16'h0000, 16'd10);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (c == 5) reset = 1'b1;
        end
        @(posedge clock); #1;
        reset = 1'b0;
        #3;
        b6 = busy;
        v6 = out_valid;
        a6 = ram_read_addr;
        lit("t5_busy", 32'(b6), 32'(0));
        lit("t5_valid", 32'(v6), 32'(0));
        lit("t5_raddr", 32'(a6), 32'(0));
        base = beats_seen;
        run_burst(16'h0003, 16'd3, 1'b0, 0, fv, dc);
        lit("t5_first_valid", 32'(fv), 32'(3));
        lit("t5_done_cycle", 32'(dc), 32'(6));
        lit("t5_beats", 32'(beats_seen - base), 32'(3));
        lit("t5_last_data", 32'(last_data), 32'h05);

        // Start pulsed while busy must be ignored
        base = beats_seen;
        run_burst(16'h0020, 16'd5, 1'b0, 2, fv, dc);
        lit("t6_done_cycle", 32'(dc), 32'(8));
        lit("t6_beats", 32'(beats_seen - base), 32'(5));
        lit("t6_last_data", 32'(last_data), 32'h24);
        repeat (4) @(posedge clock);
        #4;
        lit("t6_idle_after", 32'(busy), 32'(0));

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
